uart_rx_sequencer: RTL and testbench

Controller that sequences the UART receive datapath. It drives the receiver's `clear` input, watches its 16-bit status/data word, and pushes each completed byte into a small FIFO with a valid/ready interface for the consumer. It sits between the UART receiver and the CPU/memory-mapped side, so software never has to pulse `clear` itself.

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_rx_sequencer.sv | 143 ++++++++++++++
 tb/tb_uart_rx_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // Receive sequencer states, in the order a frame walks through them.
  typedef enum logic [2:0] {
    RESET_IDLE = 3'd0,
    CLEAR      = 3'd1,
    ARM        = 3'd2,
    WAIT       = 3'd3,
    CAPTURE    = 3'd4
  } rx_seq_state_t;

  // Receiver status word: bit 15 high = armed/ready, low = byte complete.
  localparam int UART_READY_BIT = 15;
  localparam int UART_BYTE_W    = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/full/empty/count; head is a combinational read.
// Latency: pushed entry visible at the head one cycle after the push edge.
// Backpressure: push while full is refused unless a pop lands in the same cycle.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];

  // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // Storage: cleared on reset so the head reads 0 while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointers wrap naturally (power-of-two depth); count tracks push minus pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_sequencer.sv
// Sequences UART receiver clear/arm/capture and queues bytes; optional ARM watchdog under UART_RX_TIMEOUT_EN.
// Latency: ready bit falls in cycle N -> CAPTURE at N+1 -> byte at FIFO head and rx_clear pulse at N+2.
// Backpressure: m_valid/m_ready; a byte captured into a full FIFO with no pop is dropped and flags overflow.
module uart_rx_sequencer
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [15:0]                        rx_word,
  output logic                               rx_clear,
  output logic [7:0]                         m_data,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
  output logic                               overflow,
  input  logic                               clr_overflow,
  output logic                               timeout_evt
);

  rx_seq_state_t r_state;
  rx_seq_state_t w_next;
  logic          r_run;
  logic          r_rx_clear;
  logic          r_overflow;
  logic          w_capture;
  logic          w_ready;
  logic          w_full;
  logic          w_empty;
  logic          w_drop;
  logic          w_unused_rx_hi;

  assign w_ready        = rx_word[UART_READY_BIT];
  assign w_unused_rx_hi = ^rx_word[14:8];

`ifdef UART_RX_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic        w_timeout_fire;

  // Watchdog counts ARM cycles; leaving ARM (including via timeout) zeroes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (r_state == ARM) begin
      r_wdog <= r_wdog + 1'b1;
    end else begin
      r_wdog <= '0;
    end
  end

  assign w_timeout_fire = (r_state == ARM) && !w_ready &&
                          (r_wdog == 16'(TIMEOUT_CYCLES - 1));
  assign timeout_evt    = w_timeout_fire;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = (TIMEOUT_CYCLES > 1);
  assign timeout_evt  = 1'b0;
`endif

  // First edge after reset release only arms r_run, so CLEAR starts one full cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // Next-state logic: CLEAR -> ARM (wait ack) -> WAIT (wait byte) -> CAPTURE -> CLEAR.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      RESET_IDLE: if (r_run) w_next = CLEAR;
      CLEAR:      w_next = ARM;
      ARM: begin
        if (w_ready) begin
          w_next = WAIT;
        end
`ifdef UART_RX_TIMEOUT_EN
        else if (w_timeout_fire) begin
          w_next = CLEAR;
        end
`endif
      end
      WAIT:       if (!w_ready) w_next = CAPTURE;
      CAPTURE: begin
        w_capture = 1'b1;
        w_next    = CLEAR;
      end
      default:    w_next = RESET_IDLE;
    endcase
  end

  // State register plus registered rx_clear, high exactly while in CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RESET_IDLE;
      r_rx_clear <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rx_clear <= (w_next == CLEAR);
    end
  end

  assign rx_clear = r_rx_clear;

  // Drop only when full and the consumer is not freeing a slot this cycle.
  assign w_drop = w_capture & w_full & ~(m_ready & ~w_empty);

  // Sticky overflow; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;
  assign m_valid  = ~w_empty;

  sync_fifo #(
    .WIDTH (UART_BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_capture),
    .i_push_dat (rx_word[UART_BYTE_W-1:0]),
    .i_pop      (m_ready),
    .o_head_dat (m_data),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (count)
  );

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench with a byte scoreboard for uart_rx_sequencer.
// Latency: checks capture at N+1, head/rx_clear at N+2, CLEAR two cycles after reset release.
// Backpressure: holds m_ready low to fill/overflow the FIFO, raises it to pop in the CAPTURE cycle.
module tb_uart_rx_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic        clk;
  logic        rst_n;
  logic [15:0] rx_word;
  logic        rx_clear;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [2:0]  count;
  logic        overflow;
  logic        clr_overflow;
  logic        timeout_evt;

  int          tests;
  int          failed;
  logic [7:0]  exp_q [$];
  logic        exp_ovf;

  uart_rx_sequencer #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_word      (rx_word),
    .rx_clear     (rx_clear),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .timeout_evt  (timeout_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic post_checks(input string tag);
    check({tag, "_cnt"}, 32'(count), 32'(exp_q.size()));
    check({tag, "_vld"}, 32'(m_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check({tag, "_head"}, 32'(m_data), 32'(exp_q[0]));
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
  endtask

  // Entry: FSM in CLEAR or idling in ARM. Exit: FSM in CLEAR right after the capture.
  task automatic send_byte(input logic [7:0] b, input logic pop_cap);
    logic [7:0] h;
    tick();
    clr_overflow = 1'b0;
    check("clr_single", 32'(rx_clear), 32'd0);
    check("ovf_arm", 32'(overflow), 32'(exp_ovf));
    rx_word = 16'h8000;
    tick();
    rx_word = {8'h00, b};
    tick();
    check("cap_cnt", 32'(count), 32'(exp_q.size()));
    check("cap_vld", 32'(m_valid), 32'(exp_q.size() != 0));
    check("cap_noclr", 32'(rx_clear), 32'd0);
    m_ready = pop_cap;
    if (pop_cap && exp_q.size() != 0) begin
      h = exp_q.pop_front();
      check("cap_pop_dat", 32'(m_data), 32'(h));
    end
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovf = 1'b1;
    tick();
    m_ready = 1'b0;
    check("clr_pulse", 32'(rx_clear), 32'd1);
    post_checks("post");
  endtask

  task automatic drain();
    logic [7:0] h;
    m_ready = 1'b1;
    for (int g = 0; g < 2 * DEPTH && exp_q.size() != 0; g++) begin
      check("drain_vld", 32'(m_valid), 32'd1);
      h = exp_q.pop_front();
      check("drain_dat", 32'(m_data), 32'(h));
      tick();
    end
    m_ready = 1'b0;
    check("drain_empty_vld", 32'(m_valid), 32'd0);
    check("drain_empty_cnt", 32'(count), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rel_clr_c1", 32'(rx_clear), 32'd0);
    tick();
    check("rel_clr_c2", 32'(rx_clear), 32'd1);
  endtask

  initial begin
    tests        = 0;
    failed       = 0;
    exp_ovf      = 1'b0;
    rst_n        = 1'b0;
    rx_word      = 16'h0000;
    m_ready      = 1'b0;
    clr_overflow = 1'b0;
    repeat (3) tick();

    // Reset values.
    check("rst_clear", 32'(rx_clear), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_tmo", 32'(timeout_evt), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    release_reset();

    // Single byte, latency and re-pulse of rx_clear.
    send_byte(8'h41, 1'b0);
    drain();

    // Five bytes into a 4-deep FIFO: 0x05 dropped, overflow set, head 0x01.
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
    check("ovf_fill_cnt", 32'(count), 32'd4);
    check("ovf_fill_head", 32'(m_data), 32'h01);
    check("ovf_fill_flag", 32'(overflow), 32'd1);

    // Clear overflow, then capture 0x55 into the full FIFO while popping.
    clr_overflow = 1'b1;
    exp_ovf      = 1'b0;
    exp_q.delete();
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    send_byte(8'h55, 1'b1);
    check("fullpop_cnt", 32'(count), 32'd4);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    drain();

    // Reset while in WAIT with two bytes queued.
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rx_word = 16'h8000;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_cnt", 32'(count), 32'd0);
    check("midrst_vld", 32'(m_valid), 32'd0);
    check("midrst_clr", 32'(rx_clear), 32'd0);
    exp_q.delete();
    rx_word = 16'h0033;
    release_reset();

    // Stale byte held through CLEAR/ARM must not be captured.
    for (int i = 0; i < 8; i++) begin
      tick();
      check("stale_vld", 32'(m_valid), 32'd0);
      check("stale_clr", 32'(rx_clear), 32'd0);
    end
    send_byte(8'h33, 1'b0);

    // rx_word held low after rx_clear: watchdog behaviour.
    rx_word = 16'h0000;
    for (int i = 1; i <= 20; i++) begin
      tick();
`ifdef UART_RX_TIMEOUT_EN
      check("tmo_evt", 32'(timeout_evt), 32'(i == TMO));
      check("tmo_clr", 32'(rx_clear), 32'(i == TMO + 1));
`else
      check("tmo_evt", 32'(timeout_evt), 32'd0);
      check("tmo_clr", 32'(rx_clear), 32'd0);
`endif
    end
    post_checks("tmo_end");
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
